// File: rtl/fetch_unit_pkg.sv
// Shared widths, FSM encoding and opcode constants for the fetch path.
package fetch_unit_pkg;

  localparam int OPC_W = 3;
  localparam int XLEN  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_t;

  localparam logic [OPC_W-1:0] OPC_R    = 3'b000;
  localparam logic [OPC_W-1:0] OPC_ADDI = 3'b001;
  localparam logic [OPC_W-1:0] OPC_SUBI = 3'b010;
  localparam logic [OPC_W-1:0] OPC_ST   = 3'b011;
  localparam logic [OPC_W-1:0] OPC_LD   = 3'b100;
  localparam logic [OPC_W-1:0] OPC_JMP  = 3'b101;
  localparam logic [OPC_W-1:0] OPC_BEQ  = 3'b110;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection: jump beats branch, branch needs zero.
module fetch_unit_next_pc
  import fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instr,
  input  logic            jump,
  input  logic            branch,
  input  logic            zero,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] br_off;

  assign pc_inc = pc + 16'd1;
  assign br_off = {{9{instr[6]}}, instr[6:0]};

  always_comb begin
    next_pc = pc_inc;
    if (jump)
      next_pc = {pc[15:13], instr[12:0]};
    else if (branch && zero)
      next_pc = pc_inc + br_off;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: requests a word at pc, holds it for decode until consumed.
//   state    | meaning
//   ST_IDLE  | nothing outstanding, waiting for run
//   ST_FETCH | imem_req asserted at pc, waiting for imem_ack
//   ST_VALID | instr presented to decode, waiting for instr_ready
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            jump,
  input  logic            branch,
  input  logic            zero,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] retired
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc_next;

  fetch_unit_next_pc u_next_pc (
    .pc      (pc),
    .instr   (instr),
    .jump    (jump),
    .branch  (branch),
    .zero    (zero),
    .next_pc (pc_next)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      retired     <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          // Once a request is out it always completes; run is only looked at on consume.
          if (imem_ack) begin
            instr       <= imem_rdata;
            state       <= ST_VALID;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        ST_VALID: begin
          if (instr_ready) begin
            pc          <= pc_next;
            retired     <= retired + 16'd1;
            instr_valid <= 1'b0;
            if (run) begin
              state    <= ST_FETCH;
              imem_req <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic        branch;
  logic        zero;
  logic [15:0] pc;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .pc          (pc),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000;
    instr_ready = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
    #4;
    rst_n = 1'b1;
    step();
  endtask

  // Expects the DUT in FETCH: acks with word, then consumes it with the given controls.
  task automatic do_instr(input logic [15:0] word, input logic j, input logic b,
                          input logic z, input logic run_after);
    imem_ack = 1'b1; imem_rdata = word;
    step();
    imem_ack = 1'b0;
    jump = j; branch = b; zero = z; instr_ready = 1'b1; run = run_after;
    step();
    instr_ready = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000;
    instr_ready = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
    #12;
    checks++;
    if ({imem_req, instr_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_ctrl: got req/valid=%b required 00", {imem_req, instr_valid});
    end
    checks++;
    if (pc !== 16'h0000 || imem_addr !== 16'h0000) begin
      errors++; $display("FAIL reset_pc: got pc=%h addr=%h required 0000", pc, imem_addr);
    end
    checks++;
    if (instr !== 16'h0000 || retired !== 16'h0000) begin
      errors++; $display("FAIL reset_regs: got instr=%h retired=%h required 0000", instr, retired);
    end
    rst_n = 1'b1;
    step(); step();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL idle_no_run: got imem_req=%b required 0", imem_req);
    end
  endtask

  task automatic test_sequential();
    apply_reset();
    imem_ack = 1'b1; imem_rdata = 16'h0000; instr_ready = 1'b1; run = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'(i) || retired !== 16'(i)) begin
        errors++;
        $display("FAIL seq_fetch%0d: got req=%b addr=%h retired=%h required 1 %h %h",
                 i, imem_req, imem_addr, retired, 16'(i), 16'(i));
      end
      step();
      checks++;
      if (instr_valid !== 1'b1) begin
        errors++; $display("FAIL seq_valid%0d: got instr_valid=%b required 1", i, instr_valid);
      end
      step();
    end
    run = 1'b0;
    step(); step();
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 16'h0005 || retired !== 16'h0005) begin
      errors++;
      $display("FAIL seq_stop: got req=%b valid=%b pc=%h retired=%h required 0 0 0005 0005",
               imem_req, instr_valid, pc, retired);
    end
    step();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL seq_stay_idle: got imem_req=%b required 0", imem_req);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    run = 1'b1;
    step();
    do_instr(16'h007E, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_neg_branch: got req=%b addr=%h required 1 FFFF", imem_req, imem_addr);
    end
    force dut.retired = 16'hFFFF;
    #1;
    release dut.retired;
    do_instr(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc !== 16'h0000) begin
      errors++; $display("FAIL wrap_pc: got pc=%h required 0000", pc);
    end
    checks++;
    if (retired !== 16'h0000) begin
      errors++; $display("FAIL wrap_retired: got retired=%h required 0000", retired);
    end
  endtask

  task automatic test_jump_priority();
    apply_reset();
    run = 1'b1;
    step();
    do_instr(16'hBFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    do_instr(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (imem_addr !== 16'h2000) begin
      errors++; $display("FAIL jump_region_carry: got addr=%h required 2000", imem_addr);
    end
    do_instr(16'hA005, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (imem_addr !== 16'h2005) begin
      errors++; $display("FAIL jump_keep_top: got addr=%h required 2005", imem_addr);
    end
    do_instr(16'hA123, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (pc !== 16'h2123) begin
      errors++; $display("FAIL jump_over_branch: got pc=%h required 2123", pc);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    run = 1'b1;
    step();
    do_instr(16'hA010, 1'b1, 1'b0, 1'b0, 1'b1);
    do_instr(16'hC07E, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (imem_addr !== 16'h000F) begin
      errors++; $display("FAIL branch_taken: got addr=%h required 000F", imem_addr);
    end
    do_instr(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    do_instr(16'hC07E, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc !== 16'h0011 || retired !== 16'h0004) begin
      errors++; $display("FAIL branch_not_taken: got pc=%h retired=%h required 0011 0004", pc, retired);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    run = 1'b1;
    step();
    imem_rdata = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_fetch%0d: got req=%b addr=%h valid=%b required 1 0000 0", i,
                 imem_req, imem_addr, instr_valid);
      end
      step();
    end
    imem_ack = 1'b1; imem_rdata = 16'h5678;
    step();
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr !== 16'h5678 || pc !== 16'h0000 || retired !== 16'h0000) begin
        errors++;
        $display("FAIL stall_valid%0d: got valid=%b instr=%h pc=%h retired=%h required 1 5678 0000 0000",
                 i, instr_valid, instr, pc, retired);
      end
    end
    imem_ack = 1'b0; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    step();
    checks++;
    if (retired !== 16'h0001 || imem_addr !== 16'h0001 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL stall_consume: got retired=%h addr=%h req=%b required 0001 0001 1",
               retired, imem_addr, imem_req);
    end
  endtask

  task automatic test_reset_mid_fetch();
    apply_reset();
    run = 1'b1;
    step();
    do_instr(16'h4321, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 16'h0000 ||
        instr !== 16'h0000 || retired !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: got req=%b valid=%b pc=%h instr=%h retired=%h required 0 0 0000 0000 0000",
               imem_req, instr_valid, pc, instr, retired);
    end
    run = 1'b0;
    #2;
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (instr !== 16'h0000 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stray_ack%0d: got instr=%h valid=%b req=%b required 0000 0 0", i,
                 instr, instr_valid, imem_req);
      end
    end
    run = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++; $display("FAIL restart_addr: got req=%b addr=%h required 1 0000", imem_req, imem_addr);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'hBEEF) begin
      errors++; $display("FAIL restart_instr: got valid=%b instr=%h required 1 BEEF", instr_valid, instr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_jump_priority();
    test_branch();
    test_stall();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
